ls_access_arbiter: RTL and testbench

// - Shares the single-port 32 KB local store (one 128-bit quadword access/cycle) among DMA, load/store unit (LSU), instruction fetch (IFU).
// - Registers winner's addr/data/write-enable to the store, captures async read data, returns tagged response. Sits between SPU pipes/DMA engine and the store.

---
 rtl/spu_ls_pkg.sv | 21 ++
 rtl/ls_arb_prio.sv | 24 ++
 rtl/ls_access_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_ls_access_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/spu_ls_pkg.sv
// Shared types and default sizes for the SPU local-store access arbiter.
package spu_ls_pkg;

    localparam int ADDR_W       = 15;
    localparam int DATA_W       = 128;
    localparam int BURST_MAX    = 16;
    localparam int STARVE_LIMIT = 8;

    // Encodings double as rsp_id values and as grant-vector bit positions.
    typedef enum logic [1:0] {
        DMA = 2'd0,
        LSU = 2'd1,
        IFU = 2'd2
    } ls_req_id_t;

    typedef enum logic {
        ARB       = 1'b0,
        DMA_BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ls_arb_prio.sv
// Combinational 3-way priority picker: DMA > LSU > IFU, with an override
// that lets a starved IFU win. Produces a one-hot (or zero) grant.
module ls_arb_prio
    import spu_ls_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic       force_ifu_i,
    output logic [2:0] gnt_o
);

    always_comb begin
        gnt_o = 3'b000;
        if (force_ifu_i && req_i[IFU]) begin
            gnt_o[IFU] = 1'b1;
        end else if (req_i[DMA]) begin
            gnt_o[DMA] = 1'b1;
        end else if (req_i[LSU]) begin
            gnt_o[LSU] = 1'b1;
        end else if (req_i[IFU]) begin
            gnt_o[IFU] = 1'b1;
        end
    end

endmodule

// File: rtl/ls_access_arbiter.sv
// Local-store access arbiter: DMA/LSU/IFU share one quadword port per cycle.
// Optional IFU starvation guard enabled by defining LS_ARB_STARVE_GUARD_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARB       | fixed-priority arbitration among all three requesters
// DMA_BURST | DMA holds the port; only DMA beats are granted
module ls_access_arbiter #(
    parameter int ADDR_W       = spu_ls_pkg::ADDR_W,
    parameter int DATA_W       = spu_ls_pkg::DATA_W,
    parameter int BURST_MAX    = spu_ls_pkg::BURST_MAX,
    parameter int STARVE_LIMIT = spu_ls_pkg::STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dma_req_valid,
    input  logic              lsu_req_valid,
    input  logic              ifu_req_valid,
    output logic              dma_req_ready,
    output logic              lsu_req_ready,
    output logic              ifu_req_ready,
    input  logic              dma_req_we,
    input  logic              lsu_req_we,
    input  logic              dma_req_last,
    input  logic [ADDR_W-1:0] dma_req_addr,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    input  logic [DATA_W-1:0] dma_req_wdata,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    output logic              LS_write_en,
    output logic [ADDR_W-1:0] LS_addr,
    output logic [DATA_W-1:0] LS_data_in,
    input  logic [DATA_W-1:0] LS_data_out,
    output logic              rsp_valid,
    output logic [1:0]        rsp_id,
    output logic [DATA_W-1:0] rsp_rdata
);
    import spu_ls_pkg::*;

    localparam int BCNT_W = $clog2(BURST_MAX + 1);

    arb_state_t        state_q;
    logic [BCNT_W-1:0] burst_cnt_q;
    logic              ls_we_q;
    logic [ADDR_W-1:0] ls_addr_q;
    logic [DATA_W-1:0] ls_wdata_q;
    logic              rd_pend_q;
    ls_req_id_t        rd_id_q;
    logic              rsp_valid_q;
    ls_req_id_t        rsp_id_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic [2:0]        req_vec;
    logic [2:0]        gnt;
    logic              starved;
    logic              force_ifu;
    logic              accept_d;
    logic              we_d;
    ls_req_id_t        id_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

`ifdef LS_ARB_STARVE_GUARD_EN
    localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
    logic [SCNT_W-1:0] starve_cnt_q;

    assign starved = (starve_cnt_q == SCNT_W'(STARVE_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else if (gnt[IFU]) begin
            starve_cnt_q <= '0;
        end else if (ifu_req_valid && !starved) begin
            starve_cnt_q <= starve_cnt_q + 1'b1;
        end
    end
`else
    assign starved = 1'b0;
`endif

    assign force_ifu = starved && (state_q == ARB);

    // The burst lock masks LSU/IFU entirely; reset forces every ready low.
    always_comb begin
        req_vec = 3'b000;
        if (!rst) begin
            if (state_q == DMA_BURST) begin
                req_vec[DMA] = dma_req_valid;
            end else begin
                req_vec = {ifu_req_valid, lsu_req_valid, dma_req_valid};
            end
        end
    end

    ls_arb_prio u_prio (
        .req_i       (req_vec),
        .force_ifu_i (force_ifu),
        .gnt_o       (gnt)
    );

    assign dma_req_ready = gnt[DMA];
    assign lsu_req_ready = gnt[LSU];
    assign ifu_req_ready = gnt[IFU];

    always_comb begin
        accept_d = |gnt;
        we_d     = 1'b0;
        id_d     = DMA;
        addr_d   = '0;
        wdata_d  = '0;
        if (gnt[DMA]) begin
            we_d    = dma_req_we;
            id_d    = DMA;
            addr_d  = {dma_req_addr[ADDR_W-1:4], 4'b0000};
            wdata_d = dma_req_wdata;
        end else if (gnt[LSU]) begin
            we_d    = lsu_req_we;
            id_d    = LSU;
            addr_d  = {lsu_req_addr[ADDR_W-1:4], 4'b0000};
            wdata_d = lsu_req_wdata;
        end else if (gnt[IFU]) begin
            id_d    = IFU;
            addr_d  = {ifu_req_addr[ADDR_W-1:4], 4'b0000};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB;
            burst_cnt_q <= '0;
            ls_we_q     <= 1'b0;
            ls_addr_q   <= '0;
            ls_wdata_q  <= '0;
            rd_pend_q   <= 1'b0;
            rd_id_q     <= DMA;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= DMA;
            rsp_rdata_q <= '0;
        end else begin
            ls_we_q   <= accept_d && we_d;
            rd_pend_q <= accept_d && !we_d;
            if (accept_d) begin
                ls_addr_q  <= addr_d;
                ls_wdata_q <= wdata_d;
                rd_id_q    <= id_d;
            end
            // Store read data is valid the cycle after the address is issued.
            rsp_valid_q <= rd_pend_q;
            if (rd_pend_q) begin
                rsp_id_q    <= rd_id_q;
                rsp_rdata_q <= LS_data_out;
            end

            case (state_q)
                ARB: begin
                    if (gnt[DMA] && !dma_req_last) begin
                        state_q     <= DMA_BURST;
                        burst_cnt_q <= BCNT_W'(1);
                    end
                end
                DMA_BURST: begin
                    if (gnt[DMA]) begin
                        if (dma_req_last || burst_cnt_q == BCNT_W'(BURST_MAX - 1)) begin
                            state_q     <= ARB;
                            burst_cnt_q <= '0;
                        end else begin
                            burst_cnt_q <= burst_cnt_q + 1'b1;
                        end
                    end
                    if (starved) begin
                        state_q     <= ARB;
                        burst_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q     <= ARB;
                    burst_cnt_q <= '0;
                end
            endcase
        end
    end

    assign LS_write_en = ls_we_q;
    assign LS_addr     = ls_addr_q;
    assign LS_data_in  = ls_wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_rdata   = rsp_rdata_q;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{dma_req_addr[3:0], lsu_req_addr[3:0], ifu_req_addr[3:0]};

endmodule

// File: tb/tb_ls_access_arbiter.sv
// Directed self-checking bench for ls_access_arbiter with a behavioural
// local store (unwritten quadwords read back a pattern derived from index).
module tb_ls_access_arbiter;

`ifdef LS_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         dma_req_valid, lsu_req_valid, ifu_req_valid;
    logic         dma_req_ready, lsu_req_ready, ifu_req_ready;
    logic         dma_req_we, lsu_req_we, dma_req_last;
    logic [14:0]  dma_req_addr, lsu_req_addr, ifu_req_addr;
    logic [127:0] dma_req_wdata, lsu_req_wdata;
    logic         LS_write_en;
    logic [14:0]  LS_addr;
    logic [127:0] LS_data_in, LS_data_out;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [127:0] rsp_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ls_access_arbiter dut (
        .clk(clk), .rst(rst),
        .dma_req_valid(dma_req_valid), .lsu_req_valid(lsu_req_valid), .ifu_req_valid(ifu_req_valid),
        .dma_req_ready(dma_req_ready), .lsu_req_ready(lsu_req_ready), .ifu_req_ready(ifu_req_ready),
        .dma_req_we(dma_req_we), .lsu_req_we(lsu_req_we), .dma_req_last(dma_req_last),
        .dma_req_addr(dma_req_addr), .lsu_req_addr(lsu_req_addr), .ifu_req_addr(ifu_req_addr),
        .dma_req_wdata(dma_req_wdata), .lsu_req_wdata(lsu_req_wdata),
        .LS_write_en(LS_write_en), .LS_addr(LS_addr), .LS_data_in(LS_data_in),
        .LS_data_out(LS_data_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata)
    );

    function automatic logic [127:0] pat(input int q);
        logic [31:0] w;
        w = 32'hC0DE0000 + 32'(q);
        return {4{w}};
    endfunction

    function automatic logic [127:0] dpat(input int k);
        logic [31:0] w;
        w = 32'hD0000000 + 32'(k);
        return {4{w}};
    endfunction

    logic [127:0] mem [0:2047];
    bit           wr_flag [0:2047];

    always @(posedge clk) begin
        if (LS_write_en) begin
            mem[LS_addr[14:4]]     <= LS_data_in;
            wr_flag[LS_addr[14:4]] <= 1'b1;
        end
    end

    assign LS_data_out = wr_flag[LS_addr[14:4]] ? mem[LS_addr[14:4]] : pat(int'(LS_addr[14:4]));

    task automatic idle_inputs();
        dma_req_valid = 0; lsu_req_valid = 0; ifu_req_valid = 0;
        dma_req_we = 0; lsu_req_we = 0; dma_req_last = 0;
        dma_req_addr = '0; lsu_req_addr = '0; ifu_req_addr = '0;
        dma_req_wdata = '0; lsu_req_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        idle_inputs();
        repeat (n) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        dma_req_valid = 1; lsu_req_valid = 1; ifu_req_valid = 1;
        rst = 1;
        @(negedge clk); @(negedge clk);
        checks++; if ({ifu_req_ready, lsu_req_ready, dma_req_ready} !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", {ifu_req_ready, lsu_req_ready, dma_req_ready}); end
        checks++; if (LS_write_en !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", LS_write_en); end
        checks++; if (LS_addr !== 15'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", LS_addr); end
        checks++; if (LS_data_in !== 128'h0) begin failures++; $display("FAIL reset_data_in got=%h exp=0", LS_data_in); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_id !== 2'b00) begin failures++; $display("FAIL reset_rsp_id got=%b exp=00", rsp_id); end
        checks++; if (rsp_rdata !== 128'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
        idle_inputs();
        tick();
        rst = 0;
    endtask

    task automatic test_lsu_read();
        tick();
        lsu_req_valid = 1; lsu_req_we = 0; lsu_req_addr = 15'h0013;
        @(negedge clk);
        checks++; if ({ifu_req_ready, lsu_req_ready, dma_req_ready} !== 3'b010) begin failures++; $display("FAIL lsu_ready got=%b exp=010", {ifu_req_ready, lsu_req_ready, dma_req_ready}); end
        tick();
        lsu_req_valid = 0;
        checks++; if (LS_addr !== 15'h0010) begin failures++; $display("FAIL lsu_ls_addr got=%h exp=0010", LS_addr); end
        checks++; if (LS_write_en !== 1'b0) begin failures++; $display("FAIL lsu_we got=%b exp=0", LS_write_en); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL lsu_rsp_early got=%b exp=0", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL lsu_rsp_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_id !== 2'b01) begin failures++; $display("FAIL lsu_rsp_id got=%b exp=01", rsp_id); end
        checks++; if (rsp_rdata !== pat(1)) begin failures++; $display("FAIL lsu_rsp_rdata got=%h exp=%h", rsp_rdata, pat(1)); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL lsu_rsp_pulse got=%b exp=0", rsp_valid); end
        drain(2);
    endtask

    task automatic test_priority();
        logic [2:0] exp_rdy [6] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000};
        logic       exp_rv  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] exp_id  [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
        for (int c = 0; c < 6; c++) begin
            tick();
            dma_req_valid = (c == 0); dma_req_last = 1; dma_req_addr = 15'h0200;
            lsu_req_valid = (c <= 1); lsu_req_addr = 15'h0210;
            ifu_req_valid = (c <= 2); ifu_req_addr = 15'h0220;
            @(negedge clk);
            checks++; if ({ifu_req_ready, lsu_req_ready, dma_req_ready} !== exp_rdy[c]) begin failures++; $display("FAIL prio_ready c=%0d got=%b exp=%b", c, {ifu_req_ready, lsu_req_ready, dma_req_ready}, exp_rdy[c]); end
            checks++; if (rsp_valid !== exp_rv[c]) begin failures++; $display("FAIL prio_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, exp_rv[c]); end
            if (exp_rv[c]) begin
                checks++; if (rsp_id !== exp_id[c]) begin failures++; $display("FAIL prio_rsp_id c=%0d got=%b exp=%b", c, rsp_id, exp_id[c]); end
                checks++; if (rsp_rdata !== pat(32'h20 + int'(exp_id[c]))) begin failures++; $display("FAIL prio_rsp_rdata c=%0d got=%h exp=%h", c, rsp_rdata, pat(32'h20 + int'(exp_id[c]))); end
            end
        end
        drain(2);
    endtask

    task automatic test_dma_burst();
        logic dv     [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic exp_we [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int b = 0;
        for (int c = 0; c < 7; c++) begin
            tick();
            dma_req_valid = dv[c]; dma_req_we = 1; dma_req_last = (b == 3);
            dma_req_addr = 15'(16'h0100 + 16'(16 * b)); dma_req_wdata = dpat(b);
            lsu_req_valid = (c <= 5); lsu_req_we = 0; lsu_req_addr = 15'h0300;
            @(negedge clk);
            checks++; if ({ifu_req_ready, lsu_req_ready, dma_req_ready} !== {1'b0, c == 5, dv[c]}) begin failures++; $display("FAIL burst_ready c=%0d got=%b exp=%b", c, {ifu_req_ready, lsu_req_ready, dma_req_ready}, {1'b0, c == 5, dv[c]}); end
            checks++; if (LS_write_en !== exp_we[c]) begin failures++; $display("FAIL burst_we c=%0d got=%b exp=%b", c, LS_write_en, exp_we[c]); end
            if (dv[c]) b++;
        end
        drain(3);
        for (int k = 0; k < 4; k++) begin
            checks++; if (mem[16 + k] !== dpat(k)) begin failures++; $display("FAIL burst_store k=%0d got=%h exp=%h", k, mem[16 + k], dpat(k)); end
        end
    endtask

    task automatic test_burst_max();
        for (int c = 0; c < 18; c++) begin
            tick();
            dma_req_valid = (c <= 15); dma_req_we = 0; dma_req_last = 0;
            dma_req_addr = 15'(16'h0400 + 16'(16 * c));
            lsu_req_valid = (c <= 16); lsu_req_we = 0; lsu_req_addr = 15'h0600;
            @(negedge clk);
            checks++; if ({ifu_req_ready, lsu_req_ready, dma_req_ready} !== {1'b0, c == 16, c <= 15}) begin failures++; $display("FAIL bmax_ready c=%0d got=%b exp=%b", c, {ifu_req_ready, lsu_req_ready, dma_req_ready}, {1'b0, c == 16, c <= 15}); end
        end
        drain(4);
    endtask

    task automatic test_starve();
        logic [2:0] exp;
        for (int c = 0; c < 12; c++) begin
            tick();
            dma_req_valid = 1; dma_req_we = 0; dma_req_last = 1; dma_req_addr = 15'h0700;
            lsu_req_valid = 1; lsu_req_we = 0; lsu_req_addr = 15'h0710;
            ifu_req_valid = GUARD ? (c <= 8) : 1'b1; ifu_req_addr = 15'h0720;
            exp = (GUARD && c == 8) ? 3'b100 : 3'b001;
            @(negedge clk);
            checks++; if ({ifu_req_ready, lsu_req_ready, dma_req_ready} !== exp) begin failures++; $display("FAIL starve_ready c=%0d got=%b exp=%b", c, {ifu_req_ready, lsu_req_ready, dma_req_ready}, exp); end
        end
        drain(4);
    endtask

    task automatic test_reset_inflight();
        tick();
        lsu_req_valid = 1; lsu_req_we = 0; lsu_req_addr = 15'h0040;
        @(negedge clk);
        checks++; if (lsu_req_ready !== 1'b1) begin failures++; $display("FAIL rstf_ready got=%b exp=1", lsu_req_ready); end
        tick();
        lsu_req_valid = 0;
        rst = 1;
        #1;
        checks++; if ({LS_write_en, LS_addr, rsp_valid, rsp_id} !== 19'h0) begin failures++; $display("FAIL rstf_outputs got=%h exp=0", {LS_write_en, LS_addr, rsp_valid, rsp_id}); end
        checks++; if (LS_data_in !== 128'h0 || rsp_rdata !== 128'h0) begin failures++; $display("FAIL rstf_data got=%h/%h exp=0", LS_data_in, rsp_rdata); end
        @(negedge clk);
        rst = 0;
        tick();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstf_no_rsp1 got=%b exp=0", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstf_no_rsp2 got=%b exp=0", rsp_valid); end
        lsu_req_valid = 1; lsu_req_addr = 15'h0050;
        @(negedge clk);
        checks++; if (lsu_req_ready !== 1'b1) begin failures++; $display("FAIL rstf_post_ready got=%b exp=1", lsu_req_ready); end
        tick();
        lsu_req_valid = 0;
        checks++; if (LS_addr !== 15'h0050) begin failures++; $display("FAIL rstf_post_addr got=%h exp=0050", LS_addr); end
        tick();
        checks++; if ({rsp_valid, rsp_id} !== 3'b101) begin failures++; $display("FAIL rstf_post_rsp got=%b exp=101", {rsp_valid, rsp_id}); end
        checks++; if (rsp_rdata !== pat(5)) begin failures++; $display("FAIL rstf_post_rdata got=%h exp=%h", rsp_rdata, pat(5)); end
        drain(2);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_lsu_read();
        test_priority();
        test_dma_burst();
        test_burst_max();
        test_starve();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
